alu_issue_ctrl: RTL

Sequences one ALU operation at a time between the decoder (control unit) and the ALU, including the multi-cycle operations (mul/div).
- Accepts a decoded op over a valid/ready handshake and latches operands.
- Pulses the ALU start, waits for the ALU's ready, then issues a single-cycle register writeback.
- Owns the sticky halt state and a watchdog on ALU completion; its busy output stalls instruction fetch.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_watchdog.sv | 30 +++
 rtl/alu_issue_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes and sequencer state encoding for the ALU issue controller.
package alu_pkg;

    localparam logic [5:0] ALUCTL_ADD  = 6'b011110;
    localparam logic [5:0] ALUCTL_MUL  = 6'b011000;
    localparam logic [5:0] ALUCTL_DIV  = 6'b011010;
    localparam logic [5:0] ALUCTL_HALT = 6'b001110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        WB   = 2'd2,
        HALT = 2'd3
    } alu_seq_state_t;

endpackage

// File: rtl/alu_watchdog.sv
// Saturating cycle counter that flags when an ALU operation has run TIMEOUT cycles.
module alu_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    localparam int              TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] r_count;

    // The start cycle is count 0, so expiry lands on the TIMEOUT-th busy cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_en && (r_count == LIMIT);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one ALU op at a time: accept, start pulse, wait for ALU ready, single-cycle writeback.
// Optional perf counters (perf_ops, perf_busy) are built when ALU_PERF_CNT_EN is defined.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int CTL_W   = 6,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [CTL_W-1:0]  issue_ctl,
    input  logic [DATA_W-1:0] issue_a,
    input  logic [DATA_W-1:0] issue_b,
    input  logic [4:0]        issue_rd,
    output logic              alu_start,
    output logic [CTL_W-1:0]  alu_ctl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_ready,
    input  logic [DATA_W-1:0] alu_out,
    output logic              rd_we,
    output logic [4:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              halted_signal,
`ifdef ALU_PERF_CNT_EN
    output logic [31:0]       perf_ops,
    output logic [31:0]       perf_busy,
`endif
    output logic              fault
);

    alu_seq_state_t    r_state;
    logic              r_issue_ready;
    logic              r_busy;
    logic              r_alu_start;
    logic [CTL_W-1:0]  r_ctl;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [4:0]        r_rd;
    logic              r_rd_we;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_halted;
    logic              r_fault;

    logic w_accept;
    logic w_is_halt;
    logic w_in_busy;
    logic w_expire;

    assign w_accept  = (r_state == IDLE) && issue_valid;
    assign w_is_halt = (issue_ctl == CTL_W'(ALUCTL_HALT));
    assign w_in_busy = (r_state == BUSY);

    alu_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_accept),
        .i_en     (w_in_busy),
        .o_expire (w_expire)
    );

    // NOTE: operand latches share the async reset so a reset mid-op leaves no stale values on alu_a/alu_b.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_issue_ready <= 1'b1;
            r_busy        <= 1'b0;
            r_alu_start   <= 1'b0;
            r_ctl         <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_rd          <= '0;
            r_rd_we       <= 1'b0;
            r_rd_data     <= '0;
            r_halted      <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_alu_start <= 1'b0;
            r_rd_we     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (issue_valid) begin
                        r_issue_ready <= 1'b0;
                        r_busy        <= 1'b1;
                        if (w_is_halt) begin
                            r_state  <= HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_state     <= BUSY;
                            r_alu_start <= 1'b1;
                            r_ctl       <= issue_ctl;
                            r_a         <= issue_a;
                            r_b         <= issue_b;
                            r_rd        <= issue_rd;
                        end
                    end
                end
                BUSY: begin
                    // A ready arriving on the expiry cycle still completes normally.
                    if (alu_ready) begin
                        r_state   <= WB;
                        r_rd_data <= alu_out;
                        r_rd_we   <= (r_rd != 5'd0);
                    end else if (w_expire) begin
                        r_state  <= HALT;
                        r_fault  <= 1'b1;
                        r_halted <= 1'b1;
                    end
                end
                WB: begin
                    r_state       <= IDLE;
                    r_issue_ready <= 1'b1;
                    r_busy        <= 1'b0;
                end
                default: begin
                    r_state <= HALT;
                end
            endcase
        end
    end

`ifdef ALU_PERF_CNT_EN
    logic [31:0] r_perf_ops;
    logic [31:0] r_perf_busy;

    // Neither counter can advance in HALT since neither WB nor BUSY is ever reached again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_ops  <= '0;
            r_perf_busy <= '0;
        end else begin
            if (r_state == WB) begin
                r_perf_ops <= r_perf_ops + 32'd1;
            end
            if (w_in_busy) begin
                r_perf_busy <= r_perf_busy + 32'd1;
            end
        end
    end

    assign perf_ops  = r_perf_ops;
    assign perf_busy = r_perf_busy;
`endif

    assign issue_ready   = r_issue_ready;
    assign busy          = r_busy;
    assign alu_start     = r_alu_start;
    assign alu_ctl       = r_ctl;
    assign alu_a         = r_a;
    assign alu_b         = r_b;
    assign rd_we         = r_rd_we;
    assign rd_addr       = r_rd;
    assign rd_data       = r_rd_data;
    assign halted_signal = r_halted;
    assign fault         = r_fault;

endmodule
